// File: rtl/graphics_processor_if.sv
// Command and framebuffer-write bundle for the rectangle fill engine.
// The master side issues commands and observes writes. The slave side is the engine.
interface graphics_processor_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 17
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [8:0]         cmd_x;
  logic [7:0]         cmd_y;
  logic [8:0]         cmd_w;
  logic [7:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               vram_we;
  logic [ADDR_W-1:0]  vram_addr;
  logic [COLOR_W-1:0] vram_data;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, vram_we, vram_addr, vram_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, vram_we, vram_addr, vram_data, busy, done
  );
endinterface

// File: rtl/graphics_processor.sv
// Rectangle fill / clear engine: clips a command to the screen, then writes
// one pixel per enabled cycle in row-major order.
//
// state  | meaning
// IDLE   | waiting for a command (ready when en=1)
// SETUP  | clip, compute row base and first address, or skip to FINISH
// DRAW   | one pixel per cycle while en=1
// FINISH | one-cycle done pulse
module graphics_processor #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOR_W  = 12,
  parameter int ADDR_W   = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  graphics_processor_if.slave gp
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;

  localparam logic [9:0]        SW10 = 10'(SCREEN_W);
  localparam logic [8:0]        SH9  = 9'(SCREEN_H);
  localparam logic [ADDR_W-1:0] SW_A = ADDR_W'(SCREEN_W);

  state_t state, state_nxt;

  logic               lat_fill;
  logic [8:0]         lat_x;
  logic [7:0]         lat_y;
  logic [9:0]         lat_w;
  logic [8:0]         lat_h;
  logic [COLOR_W-1:0] color;
  logic [9:0]         x_end;
  logic [8:0]         y_end;
  logic [9:0]         col;
  logic [8:0]         row;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  addr;

  logic              accept;
  logic [9:0]        x_sum;
  logic [8:0]        y_sum;
  logic              skip;
  logic              col_last;
  logic              row_last;
  logic [ADDR_W-1:0] setup_base;

  assign accept     = gp.cmd_valid && gp.cmd_ready;
  // Widened sums: x+w and y+h cannot wrap before the clip compare
  assign x_sum      = {1'b0, lat_x} + lat_w;
  assign y_sum      = {1'b0, lat_y} + lat_h;
  assign skip       = !lat_fill || (lat_w == 10'd0) || (lat_h == 9'd0) ||
                      ({1'b0, lat_x} >= SW10) || ({1'b0, lat_y} >= SH9);
  assign col_last   = (col + 10'd1) >= x_end;
  assign row_last   = (row + 9'd1) >= y_end;
  assign setup_base = ADDR_W'(lat_y) * SW_A;

  assign gp.cmd_ready = rst_n && en && (state == IDLE);
  assign gp.vram_we   = (state == DRAW) && en;
  assign gp.vram_addr = addr;
  assign gp.vram_data = color;
  assign gp.busy      = (state != IDLE);
  assign gp.done      = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = skip ? FINISH : DRAW;
      DRAW:    if (en && col_last && row_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_fill <= 1'b0;
      lat_x    <= '0;
      lat_y    <= '0;
      lat_w    <= '0;
      lat_h    <= '0;
      color    <= '0;
      x_end    <= '0;
      y_end    <= '0;
      col      <= '0;
      row      <= '0;
      base     <= '0;
      addr     <= '0;
    end else begin
      if (accept) begin
        lat_fill <= (gp.cmd_op == 2'b01) || (gp.cmd_op == 2'b10);
        color    <= gp.cmd_color;
        // CLEAR is a full-screen fill
        if (gp.cmd_op == 2'b10) begin
          lat_x <= '0;
          lat_y <= '0;
          lat_w <= SW10;
          lat_h <= SH9;
        end else begin
          lat_x <= gp.cmd_x;
          lat_y <= gp.cmd_y;
          lat_w <= {1'b0, gp.cmd_w};
          lat_h <= {1'b0, gp.cmd_h};
        end
      end
      if (state == SETUP) begin
        x_end <= (x_sum > SW10) ? SW10 : x_sum;
        y_end <= (y_sum > SH9) ? SH9 : y_sum;
        col   <= {1'b0, lat_x};
        row   <= {1'b0, lat_y};
        base  <= setup_base;
        addr  <= setup_base + ADDR_W'(lat_x);
      end
      if ((state == DRAW) && en) begin
        if (!col_last) begin
          col  <= col + 10'd1;
          addr <= addr + 1'b1;
        end else if (!row_last) begin
          col  <= {1'b0, lat_x};
          row  <= row + 9'd1;
          base <= base + SW_A;
          addr <= base + SW_A + ADDR_W'(lat_x);
        end
      end
    end
  end
endmodule

// File: tb/tb_graphics_processor.sv
// Random and directed stimulus for the rectangle engine, checked every cycle
// against a pixel-list model plus literal address/latency expectations.
module tb_graphics_processor;
  localparam int SW = 320;
  localparam int SH = 240;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_rand = 1'b0;
  logic en_fixed = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  graphics_processor_if #(.COLOR_W(12), .ADDR_W(17)) g ();

  graphics_processor #(.SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(12), .ADDR_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .gp(g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always begin
    @(posedge clk);
    #2;
    en = en_rand ? (($urandom % 4) != 0) : en_fixed;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: list of pixel addresses still to be written, plus a coarse phase
  int q[$];
  int wlog[$];
  int phase = 0;        // 0 idle, 1 setup cycle, 2 writing, 3 done cycle
  logic [11:0] mcolor = '0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int dcount = 0;

  function automatic void build(input logic [1:0] op, input int x, input int y,
                                input int w, input int h);
    q.delete();
    if (op == 2'b10) begin
      x = 0; y = 0; w = SW; h = SH;
    end
    if (op == 2'b01 || op == 2'b10)
      for (int r = y; r < y + h && r < SH; r++)
        for (int c = x; c < x + w && c < SW; c++)
          q.push_back(r * SW + c);
  endfunction

  always @(negedge clk) begin
    logic exp_we;
    if (!rst_n) begin
      check("rst_we",    32'(g.vram_we),   32'd0);
      check("rst_addr",  32'(g.vram_addr), 32'd0);
      check("rst_data",  32'(g.vram_data), 32'd0);
      check("rst_busy",  32'(g.busy),      32'd0);
      check("rst_done",  32'(g.done),      32'd0);
      check("rst_ready", 32'(g.cmd_ready), 32'd0);
      phase = 0;
      q.delete();
    end else begin
      exp_we = (phase == 2) && en;
      check("busy",  32'(g.busy),      32'(phase != 0));
      check("done",  32'(g.done),      32'(phase == 3));
      check("we",    32'(g.vram_we),   32'(exp_we));
      check("ready", 32'(g.cmd_ready), 32'((phase == 0) && en));
      if (exp_we && g.vram_we && q.size() > 0) begin
        check("addr", 32'(g.vram_addr), 32'(q[0]));
        check("data", 32'(g.vram_data), 32'(mcolor));
      end
      if (g.vram_we) wlog.push_back(int'(g.vram_addr));
      if (g.done) begin
        dcount++;
        done_cyc = cyc;
      end
      case (phase)
        0: if (en && g.cmd_valid) begin
             build(g.cmd_op, int'(g.cmd_x), int'(g.cmd_y), int'(g.cmd_w), int'(g.cmd_h));
             mcolor = g.cmd_color;
             acc_cyc = cyc;
             phase = 1;
           end
        1: phase = (q.size() == 0) ? 3 : 2;
        2: if (en) begin
             void'(q.pop_front());
             if (q.size() == 0) phase = 3;
           end
        default: phase = 0;
      endcase
    end
  end

  task automatic send(input logic [1:0] op, input int x, input int y, input int w,
                      input int h, input logic [11:0] colr);
    int n;
    @(posedge clk);
    #1;
    g.cmd_valid = 1'b1;
    g.cmd_op = op;
    g.cmd_x = 9'(x);
    g.cmd_y = 8'(y);
    g.cmd_w = 9'(w);
    g.cmd_h = 8'(h);
    g.cmd_color = colr;
    n = 0;
    @(negedge clk);
    while (!g.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!g.cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    g.cmd_valid = 1'b0;
    g.cmd_op = 2'($urandom);
    g.cmd_x = 9'($urandom);
    g.cmd_y = 8'($urandom);
    g.cmd_w = 9'($urandom);
    g.cmd_h = 8'($urandom);
    g.cmd_color = 12'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (g.busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (g.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wlog.size() < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (wlog.size() < target) check("write_timeout", 32'(wlog.size()), 32'(target));
  endtask

  initial begin
    int mark;
    int dc0;
    int e37[6];
    int e38[4];
    int e42[4];
    e37 = '{1610, 1611, 1612, 1930, 1931, 1932};
    e38 = '{76478, 76479, 76798, 76799};
    e42 = '{321, 322, 641, 642};
    g.cmd_valid = 1'b0;
    g.cmd_op = '0;
    g.cmd_x = '0;
    g.cmd_y = '0;
    g.cmd_w = '0;
    g.cmd_h = '0;
    g.cmd_color = '0;
    en_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // small rectangle
    mark = wlog.size();
    send(2'b01, 10, 5, 3, 2, 12'hF00);
    wait_idle(100);
    check("r37_count", 32'(wlog.size() - mark), 32'd6);
    for (int i = 0; i < 6; i++)
      if (mark + i < wlog.size()) check("r37_addr", 32'(wlog[mark + i]), 32'(e37[i]));
    check("r37_latency", 32'(done_cyc - acc_cyc), 32'd8);

    // bottom-right clipping
    mark = wlog.size();
    send(2'b01, 318, 238, 10, 10, 12'h0AB);
    wait_idle(100);
    check("r38_count", 32'(wlog.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++)
      if (mark + i < wlog.size()) check("r38_addr", 32'(wlog[mark + i]), 32'(e38[i]));
    check("r38_latency", 32'(done_cyc - acc_cyc), 32'd6);

    // degenerate commands
    mark = wlog.size();
    send(2'b01, 5, 5, 0, 3, 12'h111);
    wait_idle(20);
    check("w0_latency", 32'(done_cyc - acc_cyc), 32'd2);
    send(2'b01, 400, 5, 4, 3, 12'h222);
    wait_idle(20);
    check("x400_latency", 32'(done_cyc - acc_cyc), 32'd2);
    send(2'b11, 0, 0, 4, 4, 12'h333);
    wait_idle(20);
    check("degen_writes", 32'(wlog.size() - mark), 32'd0);

    // full clear
    mark = wlog.size();
    dc0 = dcount;
    send(2'b10, 7, 9, 3, 3, 12'h000);
    wait_idle(80000);
    check("clr_count", 32'(wlog.size() - mark), 32'd76800);
    if (wlog.size() > mark) begin
      check("clr_first", 32'(wlog[mark]), 32'd0);
      check("clr_last", 32'(wlog[wlog.size() - 1]), 32'd76799);
    end
    check("clr_dones", 32'(dcount - dc0), 32'd1);

    // enable gap mid-rectangle
    mark = wlog.size();
    send(2'b01, 20, 20, 4, 3, 12'h123);
    wait_writes(mark + 5);
    @(posedge clk);
    #1 en_fixed = 1'b0;
    repeat (5) @(posedge clk);
    #1 en_fixed = 1'b1;
    wait_idle(100);
    check("gap_count", 32'(wlog.size() - mark), 32'd12);
    if (wlog.size() > mark) check("gap_last", 32'(wlog[wlog.size() - 1]), 32'(22 * SW + 23));
    check("gap_latency", 32'(done_cyc - acc_cyc), 32'd19);

    // reset during a draw
    mark = wlog.size();
    dc0 = dcount;
    send(2'b01, 0, 100, 4, 4, 12'h0F0);
    wait_writes(mark + 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_now_we", 32'(g.vram_we), 32'd0);
    check("rst_now_busy", 32'(g.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("rst_no_done", 32'(dcount - dc0), 32'd0);
    check("rst_partial", 32'(wlog.size() - mark < 16), 32'd1);
    mark = wlog.size();
    send(2'b01, 1, 1, 2, 2, 12'h555);
    wait_idle(100);
    check("post_rst_count", 32'(wlog.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++)
      if (mark + i < wlog.size()) check("post_rst_addr", 32'(wlog[mark + i]), 32'(e42[i]));
    check("post_rst_done", 32'(dcount - dc0), 32'd1);

    // random commands with random enable stalls
    en_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int rx, ry, rw, rh, sel;
      logic [1:0] rop;
      sel = $urandom_range(0, 9);
      rop = (sel < 7) ? 2'b01 : ((sel == 7) ? 2'b00 : 2'b11);
      rx = $urandom_range(0, 340);
      ry = $urandom_range(0, 250);
      rw = $urandom_range(0, 16);
      rh = $urandom_range(0, 8);
      if ($urandom_range(0, 4) == 0) begin
        rx = SW - $urandom_range(1, 8);
        rw = $urandom_range(300, 511);
      end
      send(rop, rx, ry, rw, rh, 12'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle(2000);
    end
    wait_idle(2000);
    en_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
